// File: rtl/uart_move_decoder.sv
// Frames 6-byte move packets (sync, 4 coordinates, xor checksum) from a UART byte stream,
// presents accepted moves on a valid/ready port and reports rejected packets with err/err_code.
module uart_move_decoder #(
    parameter int         BOARD_SIZE = 11,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [3:0] from_x,
    output logic [3:0] from_y,
    output logic [3:0] to_x,
    output logic [3:0] to_y,
    output logic       err,
    output logic [2:0] err_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHKB
    } state_t;

    localparam logic [20:0] TMO_LAST  = 21'(TIMEOUT - 1);
    localparam logic [7:0]  BOARD_LIM = 8'(BOARD_SIZE);

    localparam logic [2:0] ERR_CHECKSUM = 3'd1;
    localparam logic [2:0] ERR_RANGE    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERRUN  = 3'd4;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [20:0]     tmo_q, tmo_d;
    logic [3:0][7:0] payload_q, payload_d;
    logic [3:0][3:0] coord_q, coord_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [2:0]      code_q, code_d;

    logic [3:0]      range_hit;
    logic [3:0][3:0] coord_new;
    logic [7:0]      chk_calc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_coord
            assign range_hit[gi] = (payload_q[gi] >= BOARD_LIM);
            assign coord_new[gi] = payload_q[gi][3:0];
        end
    endgenerate

    assign chk_calc = payload_q[0] ^ payload_q[1] ^ payload_q[2] ^ payload_q[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            payload_q <= '0;
            coord_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            payload_q <= payload_d;
            coord_q   <= coord_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        payload_d = payload_q;
        coord_d   = coord_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        code_d    = code_q;

        // A commit below overrides this, so a same-cycle handoff keeps valid high.
        if (valid_q && move_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_done && rx_data == SYNC_BYTE) begin
                    state_d = S_PAYLOAD;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end
            S_PAYLOAD, S_CHKB: begin
                // rx_done wins over the timeout, so a byte in the last allowed cycle is kept.
                if (rx_done) begin
                    tmo_d = '0;
                    if (state_q == S_PAYLOAD) begin
                        payload_d[idx_q] = rx_data;
                        idx_d            = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = S_CHKB;
                        end
                    end else begin
                        state_d = S_IDLE;
                        if (rx_data != chk_calc) begin
                            err_d  = 1'b1;
                            code_d = ERR_CHECKSUM;
                        end else if (|range_hit) begin
                            err_d  = 1'b1;
                            code_d = ERR_RANGE;
                        end else if (valid_q && !move_ready) begin
                            err_d  = 1'b1;
                            code_d = ERR_OVERRUN;
                        end else begin
                            coord_d = coord_new;
                            valid_d = 1'b1;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_IDLE;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 21'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign move_valid = valid_q;
    assign from_x     = coord_q[0];
    assign from_y     = coord_q[1];
    assign to_x       = coord_q[2];
    assign to_y       = coord_q[3];
    assign err        = err_q;
    assign err_code   = code_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_move_decoder.md
# uart_move_decoder

Packet framer and command controller that sits between the UART receiver and the game logic. It consumes the receiver's parallel byte and one-cycle done strobe and assembles fixed-length move packets. It validates sync, coordinate range and checksum, and enforces an inter-byte timeout. Each accepted move is presented to the game FSM through a valid/ready handshake, and every rejected packet is reported with a one-cycle error pulse and code.

## Interface
- BOARD_SIZE, 11: legal coordinate range is 0..BOARD_SIZE-1.
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT, 2_000_000: maximum clk cycles between consecutive packet bytes (20 ms at 100 MHz).
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only in cycles where rx_done=1.
- rx_done  in  1  one-cycle strobe, one per received byte.
- move_valid  out  1  a decoded move is being presented.
- move_ready  in  1  game logic accepts the move.
- from_x, from_y, to_x, to_y  out  4 each  move coordinates; stable while move_valid=1.
- err  out  1  one-cycle pulse when a packet is rejected.
- err_code  out  3  error cause; held until the next err pulse.
- busy  out  1  high while a packet is partially received.

## Operation
- Packet (6 bytes): SYNC_BYTE, from_x, from_y, to_x, to_y, chk.
- Checksum rule: chk = from_x ^ from_y ^ to_x ^ to_y, computed as 8-bit XOR over the full bytes.
- States:
  - IDLE: wait for a byte.
    - rx_done with rx_data==SYNC_BYTE -> PAYLOAD, idx=0, tmo=0.
    - Any other byte is ignored silently, with no err pulse.
  - PAYLOAD: each rx_done stores rx_data into payload[idx], idx++, and clears tmo.
    - When the 4th payload byte is stored -> CHKB.
    - While no byte arrives, tmo increments; tmo reaching TIMEOUT-1 -> err, code 3, -> IDLE.
    - A SYNC_BYTE value inside the payload is treated as data, not as a resync.
  - CHKB: wait for the chk byte, with the same timeout rule as PAYLOAD.
    - On rx_done, evaluate in this priority order:
      - chk mismatch -> err, code 1;
      - else any coordinate byte >= BOARD_SIZE -> err, code 2;
      - else move_valid already high and move_ready=0 this cycle -> err, code 4 (overrun), new move dropped;
      - else load the coordinate outputs from payload[3:0] of each byte and set move_valid.
    - Always return to IDLE.
- Handshake:
  - move_valid stays high until a cycle where move_ready=1; it then clears on the next edge.
  - If a new move commits in the same cycle as move_ready=1 on the old move, the new move is loaded and move_valid stays high. No overrun is reported.
- busy = (state != IDLE).
- err_code values: 0 none, 1 checksum, 2 range, 3 timeout, 4 overrun.

## Timing
- Reset values: move_valid=0, err=0, err_code=0, busy=0, all coordinates=0, state=IDLE, idx=0, tmo=0.
- Reset mid-packet discards the partial packet and any pending move, asynchronously.
- Latency:
  - move_valid rises on the first clk edge after the edge that samples rx_done=1 for the chk byte.
  - err pulses with the same 1-cycle latency and is high for exactly one cycle.
- rx_done is level-sampled each cycle. Each pulse is exactly one cycle wide, so there is no double count.
- The timeout counter is 21 bits and saturates; it is never wrapped.
- Timeout boundary: a byte arriving in the very cycle tmo==TIMEOUT-1 is accepted, because rx_done has priority over timeout.
- Minimum packet spacing is limited only by the UART. A back-to-back SYNC byte in the cycle after return to IDLE is accepted.

## Test plan
- Valid packet: A5,02,03,02,07,04 with move_ready tied high -> move_valid high for 1 cycle; from=(2,3), to=(2,7); err never pulses.
- Bad checksum: A5,01,01,01,05,00 -> err pulse, err_code=1, move_valid stays 0, busy returns to 0.
- Range error: A5,0B,00,00,00,0B (BOARD_SIZE=11) -> err pulse, err_code=2.
- Timeout: A5,01, then silence with TIMEOUT=100 -> err at cycle 100 after the last rx_done, code 3. A following valid packet decodes correctly.
- Overrun and handshake:
  - Two valid packets with move_ready=0 -> first move is held; second gives err code 4; outputs still show the first move.
  - Raising move_ready in the chk cycle of the second packet loads the second move instead.
- Reset mid-packet: assert reset after byte 3 -> all outputs are at reset values immediately. A fresh valid packet after release decodes normally.
